// File: rtl/nx_fifo_ctrl_wm.sv
// nx_fifo_ctrl_wm: FIFO pointer/occupancy controller with programmable watermarks
// and diagnostic state. It drives the read/write addresses of an external RAM and
// provides registered flow-control status. DEPTH may be any integer in 2..1024.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   wen, ren          write / read requests
//   clear             synchronous flush (highest priority over wen/ren)
//   afull_thresh      almost-full watermark (used_slots >= thresh)
//   aempty_thresh     almost-empty watermark (used_slots <= thresh)
//   err_clr           clears both sticky error flags (a new error wins)
//   peak_clr          restarts peak-occupancy tracking
//   empty, full       registered occupancy flags
//   afull, aempty     combinational watermark compares on used_slots
//   used_slots        registered occupancy
//   free_slots        registered DEPTH - used_slots
//   wptr, rptr        registered RAM write / read addresses
//   overflow          combinational pulse: write attempted while full
//   underflow         combinational pulse: read attempted while empty
//   ovf_sticky        latched overflow
//   unf_sticky        latched underflow
//   peak_used         maximum occupancy since reset or peak_clr
module nx_fifo_ctrl_wm #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic             ren,
    input  logic             clear,
    input  logic [CNT_W-1:0] afull_thresh,
    input  logic [CNT_W-1:0] aempty_thresh,
    input  logic             err_clr,
    input  logic             peak_clr,
    output logic             empty,
    output logic             full,
    output logic             afull,
    output logic             aempty,
    output logic [CNT_W-1:0] used_slots,
    output logic [CNT_W-1:0] free_slots,
    output logic [PTR_W-1:0] wptr,
    output logic [PTR_W-1:0] rptr,
    output logic             overflow,
    output logic             underflow,
    output logic             ovf_sticky,
    output logic             unf_sticky,
    output logic [CNT_W-1:0] peak_used
);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] used_q, used_d, free_q, free_d, peak_q, peak_d;
    logic             empty_q, empty_d, full_q, full_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             wr_acc, rd_acc;

    // Acceptance uses the registered flags, so a write while full is refused
    // even when a read is accepted in the same cycle.
    assign wr_acc    = wen & ~full_q & ~clear;
    assign rd_acc    = ren & ~empty_q & ~clear;
    assign overflow  = wen & full_q & ~clear;
    assign underflow = ren & empty_q & ~clear;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        used_d = used_q;

        if (clear) begin
            wptr_d = '0;
            rptr_d = '0;
            used_d = '0;
        end else begin
            // Explicit wrap at DEPTH-1 keeps non-power-of-two depths in range.
            if (wr_acc) begin
                wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   used_d = used_q + CNT_ONE;
                2'b01:   used_d = used_q - CNT_ONE;
                default: used_d = used_q;
            endcase
        end

        free_d  = DEPTH_C - used_d;
        full_d  = (used_d == DEPTH_C);
        empty_d = (used_d == '0);

        // A coincident error beats err_clr.
        ovf_d = overflow | (ovf_q & ~err_clr);
        unf_d = underflow | (unf_q & ~err_clr);

        if (peak_clr) begin
            peak_d = used_d;
        end else begin
            peak_d = (used_d > peak_q) ? used_d : peak_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            used_q  <= '0;
            free_q  <= DEPTH_C;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            peak_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            used_q  <= used_d;
            free_q  <= free_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            peak_q  <= peak_d;
        end
    end

    assign empty      = empty_q;
    assign full       = full_q;
    assign used_slots = used_q;
    assign free_slots = free_q;
    assign wptr       = wptr_q;
    assign rptr       = rptr_q;
    assign ovf_sticky = ovf_q;
    assign unf_sticky = unf_q;
    assign peak_used  = peak_q;

    // Watermarks compare straight off the registered count: threshold 0 makes
    // afull constant 1 and a threshold above DEPTH makes it unreachable.
    assign afull  = (used_q >= afull_thresh);
    assign aempty = (used_q <= aempty_thresh);

endmodule
